store_write_buffer: RTL and testbench

Posted-write FIFO between the pipeline's MEM stage and the main-memory port for write-through stores. It accepts one word store per cycle, so the pipeline does not wait on memory for writes. It drains the oldest entry whenever the memory arbiter grants it the port. It reports whether any pending store falls in a given cache block, so a D-cache miss fill can be held until stale data in memory has been overwritten.

---
 rtl/store_write_buffer.sv | 92 +++++++++
 tb/tb_store_write_buffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// Posted-write buffer for write-through stores: accepts one store per cycle,
// drains the oldest entry on grant, coalesces repeat stores to the newest entry.
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    output logic                     st_ready,
    output logic                     mem_req,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_data,
    input  logic                     mem_grant,
    input  logic [AW-1:0]            chk_addr,
    output logic                     chk_hit,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [PW:0]   count_q;

    logic          full;
    logic          push;
    logic          pop;
    logic          coalesce;
    logic          alloc;
    logic [PW-1:0] newest;
    logic [PW-1:0] idx;

    always_comb begin
        full     = (count_q == FULL_CNT);
        st_ready = ~full;
        mem_req  = (count_q != '0);
        empty    = (count_q == '0);
        count    = count_q;
        mem_addr = addr_q[head_q];
        mem_data = data_q[head_q];
        newest   = tail_q - 1'b1;
        push     = st_valid & ~full;
        pop      = mem_req & mem_grant;
        // A single entry that is draining this cycle can no longer absorb data.
        coalesce = push & mem_req & (st_addr == addr_q[newest])
                   & ~((count_q == (PW+1)'(1)) & pop);
        alloc    = push & ~coalesce;
    end

    // Block match over live entries only, walking from head by age.
    always_comb begin
        chk_hit = 1'b0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (((PW+1)'(i) < count_q) && ((addr_q[idx] >> 4) == (chk_addr >> 4)))
                chk_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (alloc) begin
                addr_q[tail_q] <= st_addr;
                data_q[tail_q] <= st_data;
                tail_q         <= tail_q + 1'b1;
            end
            if (coalesce)
                data_q[newest] <= st_data;
            if (pop)
                head_q <= head_q + 1'b1;
            count_q <= count_q + (PW+1)'(alloc) - (PW+1)'(pop);
        end
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed vector table, corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_store_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_grant;
    logic [AW-1:0] chk_addr;
    logic          chk_hit;
    logic          empty;
    logic [$clog2(DEPTH):0] count;

    store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_grant(mem_grant),
        .chk_addr(chk_addr), .chk_hit(chk_hit), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
    ent_t q[$];

    typedef struct {
        logic v; logic [AW-1:0] a; logic [DW-1:0] d; logic g; logic [AW-1:0] c;
        int cnt; logic rdy; logic req; logic [AW-1:0] ea; logic [DW-1:0] ed; logic hit;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        int  n;
        bit  hit;
        n   = q.size();
        hit = 1'b0;
        foreach (q[i]) if (q[i].a[AW-1:4] == chk_addr[AW-1:4]) hit = 1'b1;
        chk("m_count", 32'(count), 32'(n));
        chk("m_empty", 32'(empty), 32'(n == 0));
        chk("m_ready", 32'(st_ready), 32'(n < DEPTH));
        chk("m_req", 32'(mem_req), 32'(n > 0));
        chk("m_hit", 32'(chk_hit), 32'(hit));
        if (n > 0) begin
            chk("m_addr", 32'(mem_addr), 32'(q[0].a));
            chk("m_data", 32'(mem_data), 32'(q[0].d));
        end
    endtask

    // Applies the buffer rules to the queue at each clock edge.
    task automatic model_update();
        int n;
        bit pop, acc, coal;
        if (rst) begin
            q.delete();
            return;
        end
        n    = q.size();
        pop  = (n > 0) && mem_grant;
        acc  = st_valid && (n < DEPTH);
        coal = acc && (n > 0) && (st_addr == q[n-1].a) && !(n == 1 && pop);
        if (coal) q[n-1].d = st_data;
        else if (acc) q.push_back('{a: st_addr, d: st_data});
        if (pop) void'(q.pop_front());
    endtask

    task automatic apply(input logic r, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic g, input logic [AW-1:0] c);
        rst = r; st_valid = v; st_addr = a; st_data = d; mem_grant = g; chk_addr = c;
        #1;
        if (model_on) model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    function automatic vec_t mk(logic v, logic [AW-1:0] a, logic [DW-1:0] d, logic g,
                                logic [AW-1:0] c, int cnt, logic rdy, logic req,
                                logic [AW-1:0] ea, logic [DW-1:0] ed, logic hit);
        vec_t r;
        r = '{v, a, d, g, c, cnt, rdy, req, ea, ed, hit};
        return r;
    endfunction

    initial begin
        // Fill / overflow / drain
        tbl.push_back(mk(1, 16'h1000, 16'hAAAA, 0, 16'h1000, 0, 1, 0, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(1, 16'h1002, 16'hBBBB, 0, 16'h1000, 1, 1, 1, 16'h1000, 16'hAAAA, 1));
        tbl.push_back(mk(1, 16'h1004, 16'hCCCC, 0, 16'h1010, 2, 1, 1, 16'h1000, 16'hAAAA, 0));
        tbl.push_back(mk(1, 16'h1006, 16'hDDDD, 0, 16'h1000, 3, 1, 1, 16'h1000, 16'hAAAA, 1));
        tbl.push_back(mk(1, 16'h2000, 16'h1234, 0, 16'h2000, 4, 0, 1, 16'h1000, 16'hAAAA, 0));
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h2000, 4, 0, 1, 16'h1000, 16'hAAAA, 0));
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h1000, 3, 1, 1, 16'h1002, 16'hBBBB, 1));
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h0000, 2, 1, 1, 16'h1004, 16'hCCCC, 0));
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h1006, 1, 1, 1, 16'h1006, 16'hDDDD, 1));
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h1000, 0, 1, 0, 16'h0000, 16'h0000, 0));
        // Coalesce without and with a concurrent drain
        tbl.push_back(mk(1, 16'h3000, 16'h0001, 0, 16'h3000, 0, 1, 0, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(1, 16'h3000, 16'h0002, 0, 16'h3000, 1, 1, 1, 16'h3000, 16'h0001, 1));
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h3000, 1, 1, 1, 16'h3000, 16'h0002, 1));
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h3000, 1, 1, 1, 16'h3000, 16'h0002, 1));
        tbl.push_back(mk(1, 16'h3000, 16'h0001, 0, 16'h3000, 0, 1, 0, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(1, 16'h3000, 16'h0002, 1, 16'h3000, 1, 1, 1, 16'h3000, 16'h0001, 1));
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h3000, 1, 1, 1, 16'h3000, 16'h0002, 1));
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h3000, 1, 1, 1, 16'h3000, 16'h0002, 1));
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h3000, 0, 1, 0, 16'h0000, 16'h0000, 0));
        // Block hit, including exclusion of the store accepted this cycle
        tbl.push_back(mk(1, 16'h10A6, 16'h1111, 0, 16'h10A0, 0, 1, 0, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h10A0, 1, 1, 1, 16'h10A6, 16'h1111, 1));
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 16'h10B0, 1, 1, 1, 16'h10A6, 16'h1111, 0));
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h10A0, 0, 1, 0, 16'h0000, 16'h0000, 0));

        @(negedge clk);
        // Reset then idle
        apply(1, 0, '0, '0, 0, '0); tick();
        apply(1, 0, '0, '0, 0, '0); tick();
        model_on = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 16'hFFFF, 16'hFFFF, 0, 16'h0000);
            chk("rst_count", 32'(count), 0);
            chk("rst_empty", 32'(empty), 1);
            chk("rst_ready", 32'(st_ready), 1);
            chk("rst_req", 32'(mem_req), 0);
            chk("rst_hit", 32'(chk_hit), 0);
            chk("rst_addr", 32'(mem_addr), 0);
            chk("rst_data", 32'(mem_data), 0);
            tick();
        end

        foreach (tbl[i]) begin
            apply(0, tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].g, tbl[i].c);
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].cnt == 0));
            chk($sformatf("v%0d_ready", i), 32'(st_ready), 32'(tbl[i].rdy));
            chk($sformatf("v%0d_req", i), 32'(mem_req), 32'(tbl[i].req));
            chk($sformatf("v%0d_hit", i), 32'(chk_hit), 32'(tbl[i].hit));
            if (tbl[i].req) begin
                chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(tbl[i].ea));
                chk($sformatf("v%0d_data", i), 32'(mem_data), 32'(tbl[i].ed));
            end
            tick();
        end

        // Push and pop together while full: store rejected, retried next cycle
        for (int i = 0; i < DEPTH; i++) begin
            apply(0, 1, 16'h5000 + 16'(2*i), 16'(i + 1), 0, 16'h0000); tick();
        end
        apply(0, 1, 16'h4000, 16'h5555, 1, 16'h4000);
        chk("full_ready", 32'(st_ready), 0);
        tick();
        chk("full_count_after", 32'(count), DEPTH - 1);
        apply(0, 1, 16'h4000, 16'h5555, 0, 16'h4000); tick();
        chk("full_retry_count", 32'(count), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            apply(0, 0, '0, '0, 1, 16'h0000);
            if (i == DEPTH - 1) begin
                chk("full_last_addr", 32'(mem_addr), 32'h4000);
                chk("full_last_data", 32'(mem_data), 32'h5555);
            end
            tick();
        end

        // Reset with three pending entries and an active grant
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 16'h8000 + 16'(2*i), 16'hC000 + 16'(i), 0, 16'h0000); tick();
        end
        apply(1, 0, '0, '0, 1, 16'h8000); tick();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, '0, '0, 1, 16'h8000);
            chk("mid_rst_req", 32'(mem_req), 0);
            chk("mid_rst_count", 32'(count), 0);
            chk("mid_rst_empty", 32'(empty), 1);
            chk("mid_rst_hit", 32'(chk_hit), 0);
            tick();
        end

        // Wrap-around: 2*DEPTH+1 push/pop pairs
        apply(0, 1, 16'h6000, 16'h0000, 0, 16'h0000); tick();
        for (int k = 1; k <= 2*DEPTH + 1; k++) begin
            apply(0, 1, 16'h6000 + 16'(2*k), 16'(k), 1, 16'h0000);
            chk("wrap_data", 32'(mem_data), 32'(k - 1));
            chk("wrap_count", 32'(count), 1);
            tick();
        end
        apply(0, 0, '0, '0, 1, 16'h0000);
        chk("wrap_final", 32'(mem_data), 32'(2*DEPTH + 1));
        tick();
        apply(0, 0, '0, '0, 0, 16'h0000); tick();

        // Randomized traffic with a narrow address set to provoke coalescing
        for (int i = 0; i < 600; i++) begin
            logic r, v, g;
            logic [AW-1:0] a, c;
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 3) != 0);
            g = ($urandom_range(0, 1) == 1);
            a = 16'h7000 + 16'($urandom_range(0, 2)) * 16'h0002 + 16'($urandom_range(0, 1)) * 16'h0010;
            c = 16'h7000 + 16'($urandom_range(0, 2)) * 16'h0010;
            apply(r, v, a, 16'($urandom), g, c);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
